// File: rtl/line_buf_pkg.sv
// rtl/line_buf_pkg.sv - shared state encoding and default sizes for the line buffer
package line_buf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } lb_state_e;

    localparam int LB_ROW_W_DEF = 5120;
    localparam int LB_DEPTH_DEF = 10;

endpackage

// File: rtl/lb_ctrl.sv
// rtl/lb_ctrl.sv - line buffer sequencing FSM with zero-pad drain counter
module lb_ctrl
    import line_buf_pkg::*;
#(
    parameter int DEPTH = LB_DEPTH_DEF,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_enable,
    input  logic             i_we,
    input  logic             i_flush,
    input  logic [CNT_W-1:0] i_win_rows,
    output logic             o_busy,
    output logic             o_shift,
    output logic             o_shift_zero,
    output logic             o_clear,
    output logic [CNT_W-1:0] o_eff
);

    lb_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_eff_hold;
    logic             r_busy;
    logic [CNT_W-1:0] w_eff_live;

    // Clamp out-of-range window heights to the full buffer depth
    always_comb begin
        w_eff_live = i_win_rows;
        if (i_win_rows == '0 || i_win_rows > CNT_W'(DEPTH)) begin
            w_eff_live = CNT_W'(DEPTH);
        end
    end

    // Window height tracks the input while running and is frozen once draining
    assign o_eff = (r_state == ST_DRAIN) ? r_eff_hold : w_eff_live;

    // Row-array control strobes decoded from the current state
    always_comb begin
        o_shift      = 1'b0;
        o_shift_zero = (r_state == ST_DRAIN);
        o_clear      = 1'b0;
        if (!i_enable) begin
            o_clear = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE:  o_clear = 1'b1;
                ST_RUN:   o_shift = i_we;
                ST_DRAIN: begin
                    o_shift = (r_cnt != '0);
                    o_clear = (r_cnt == '0);
                end
                default:  o_clear = 1'b1;
            endcase
        end
    end

    // State, drain counter and registered busy flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_eff_hold <= '0;
            r_busy     <= 1'b0;
        end else if (!i_enable) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_RUN;
                    r_busy  <= 1'b0;
                end
                ST_RUN: begin
                    if (i_flush) begin
                        r_state    <= ST_DRAIN;
                        r_cnt      <= w_eff_live - CNT_W'(1);
                        r_eff_hold <= w_eff_live;
                        r_busy     <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/line_buffer_shift.sv
// rtl/line_buffer_shift.sv - shift-register row buffer feeding a vertical filter window
module line_buffer_shift
    import line_buf_pkg::*;
#(
    parameter int ROW_W = LB_ROW_W_DEF,
    parameter int DEPTH = LB_DEPTH_DEF,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   in_we,
    input  logic [ROW_W-1:0]       in_data,
    input  logic                   flush,
    input  logic [CNT_W-1:0]       win_rows,
    output logic [DEPTH*ROW_W-1:0] rows_out,
    output logic [DEPTH-1:0]       row_vld,
    output logic [CNT_W-1:0]       fill_cnt,
    output logic                   win_valid,
    output logic                   busy
);

    logic [DEPTH*ROW_W-1:0] r_rows;
    logic [DEPTH-1:0]       r_vld;
    logic [CNT_W-1:0]       r_fill;
    logic                   r_win_valid;

    logic                   w_shift;
    logic                   w_shift_zero;
    logic                   w_clear;
    logic [CNT_W-1:0]       w_eff;
    logic [CNT_W-1:0]       w_eff_m1;
    logic [ROW_W-1:0]       w_row_in;
    logic [DEPTH*ROW_W-1:0] w_rows_next;
    logic [DEPTH-1:0]       w_vld_next;
    logic [CNT_W-1:0]       w_pop;
    logic                   w_bottom;

    lb_ctrl #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_enable     (enable),
        .i_we         (in_we),
        .i_flush      (flush),
        .i_win_rows   (win_rows),
        .o_busy       (busy),
        .o_shift      (w_shift),
        .o_shift_zero (w_shift_zero),
        .o_clear      (w_clear),
        .o_eff        (w_eff)
    );

    // Drain pushes zero pad rows; otherwise the incoming SRAM row enters at row 0
    assign w_row_in    = w_shift_zero ? '0 : in_data;
    assign w_rows_next = {r_rows[(DEPTH-1)*ROW_W-1:0], w_row_in};
    assign w_vld_next  = {r_vld[DEPTH-2:0], ~w_shift_zero};
    assign w_eff_m1    = w_eff - CNT_W'(1);

    // Post-shift occupancy count and bottom-of-window validity
    always_comb begin
        w_pop    = '0;
        w_bottom = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            w_pop = w_pop + CNT_W'(w_vld_next[k]);
            if (CNT_W'(k) == w_eff_m1) begin
                w_bottom = w_vld_next[k];
            end
        end
    end

    // Row array shift, clear and window-valid pulse
    always_ff @(posedge clk) begin
        if (!rst_n || w_clear) begin
            r_rows      <= '0;
            r_vld       <= '0;
            r_fill      <= '0;
            r_win_valid <= 1'b0;
        end else if (w_shift) begin
            r_rows      <= w_rows_next;
            r_vld       <= w_vld_next;
            r_fill      <= w_pop;
            r_win_valid <= w_bottom;
        end else begin
            r_win_valid <= 1'b0;
        end
    end

    assign rows_out  = r_rows;
    assign row_vld   = r_vld;
    assign fill_cnt  = r_fill;
    assign win_valid = r_win_valid;

endmodule

// File: tb/tb_line_buffer_shift.sv
// tb/tb_line_buffer_shift.sv - directed self-checking bench for line_buffer_shift
module tb_line_buffer_shift;

    localparam int ROW_W = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic                   clk;
    logic                   rst_n;
    logic                   enable;
    logic                   in_we;
    logic [ROW_W-1:0]       in_data;
    logic                   flush;
    logic [CNT_W-1:0]       win_rows;
    logic [DEPTH*ROW_W-1:0] rows_out;
    logic [DEPTH-1:0]       row_vld;
    logic [CNT_W-1:0]       fill_cnt;
    logic                   win_valid;
    logic                   busy;

    int tests_run;
    int tests_failed;

    logic [40:0] obs;
    assign obs = {rows_out, row_vld, fill_cnt, win_valid, busy};

    line_buffer_shift #(
        .ROW_W (ROW_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .in_we     (in_we),
        .in_data   (in_data),
        .flush     (flush),
        .win_rows  (win_rows),
        .rows_out  (rows_out),
        .row_vld   (row_vld),
        .fill_cnt  (fill_cnt),
        .win_valid (win_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; in_we = 1'b1; flush = 1'b1;
        in_data = 8'hEE; win_rows = 3'd3;
        step();
        tests_run++;
        if (obs !== {32'h0, 4'b0000, 3'd0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset: got %h required %h", obs, {32'h0, 4'b0000, 3'd0, 1'b0, 1'b0});
        end
        rst_n = 1'b1; in_we = 1'b0; flush = 1'b0; enable = 1'b0;
        step();
    endtask

    task automatic test_fill();
        logic [40:0] exp_v [3];
        logic [7:0]  dat [3];
        dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33;
        exp_v[0] = {32'h00000011, 4'b0001, 3'd1, 1'b0, 1'b0};
        exp_v[1] = {32'h00001122, 4'b0011, 3'd2, 1'b0, 1'b0};
        exp_v[2] = {32'h00112233, 4'b0111, 3'd3, 1'b1, 1'b0};
        enable = 1'b1; win_rows = 3'd3;
        step();
        for (int i = 0; i < 3; i++) begin
            in_we = 1'b1; in_data = dat[i];
            step();
            tests_run++;
            if (obs !== exp_v[i]) begin
                tests_failed++;
                $display("FAIL fill_%0d: got %h required %h", i, obs, exp_v[i]);
            end
        end
        in_we = 1'b0;
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) begin
            step();
            tests_run++;
            if (obs !== {32'h00112233, 4'b0111, 3'd3, 1'b0, 1'b0}) begin
                tests_failed++;
                $display("FAIL hold_%0d: got %h required %h", i, obs, {32'h00112233, 4'b0111, 3'd3, 1'b0, 1'b0});
            end
        end
    endtask

    task automatic test_overflow();
        in_we = 1'b1; in_data = 8'h44;
        step();
        tests_run++;
        if (obs !== {32'h11223344, 4'b1111, 3'd4, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL overflow_44: got %h required %h", obs, {32'h11223344, 4'b1111, 3'd4, 1'b1, 1'b0});
        end
        in_data = 8'h55;
        step();
        tests_run++;
        if (obs !== {32'h22334455, 4'b1111, 3'd4, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL overflow_55: got %h required %h", obs, {32'h22334455, 4'b1111, 3'd4, 1'b1, 1'b0});
        end
        in_we = 1'b0;
    endtask

    task automatic test_drain();
        logic [40:0] exp_v [4];
        exp_v[0] = {32'h22334455, 4'b1111, 3'd4, 1'b0, 1'b1};
        exp_v[1] = {32'h33445500, 4'b1110, 3'd3, 1'b1, 1'b1};
        exp_v[2] = {32'h44550000, 4'b1100, 3'd2, 1'b1, 1'b1};
        exp_v[3] = {32'h00000000, 4'b0000, 3'd0, 1'b0, 1'b0};
        flush = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            flush = 1'b0;
            in_we = 1'b1; in_data = 8'hF0;
            tests_run++;
            if (obs !== exp_v[i]) begin
                tests_failed++;
                $display("FAIL drain_%0d: got %h required %h", i, obs, exp_v[i]);
            end
        end
        in_we = 1'b0;
        step();
    endtask

    task automatic test_eff_one_write_flush();
        win_rows = 3'd1;
        in_we = 1'b1; in_data = 8'hAA; flush = 1'b1;
        step();
        in_we = 1'b0; flush = 1'b0;
        tests_run++;
        if (obs !== {32'h000000AA, 4'b0001, 3'd1, 1'b1, 1'b1}) begin
            tests_failed++;
            $display("FAIL eff1_entry: got %h required %h", obs, {32'h000000AA, 4'b0001, 3'd1, 1'b1, 1'b1});
        end
        step();
        tests_run++;
        if (obs !== {32'h0, 4'b0000, 3'd0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL eff1_exit: got %h required %h", obs, {32'h0, 4'b0000, 3'd0, 1'b0, 1'b0});
        end
        step();
    endtask

    task automatic test_abort_enable();
        logic [7:0] dat [4];
        dat[0] = 8'h01; dat[1] = 8'h02; dat[2] = 8'h03; dat[3] = 8'h04;
        win_rows = 3'd0;
        for (int i = 0; i < 4; i++) begin
            in_we = 1'b1; in_data = dat[i];
            step();
            if (i == 2) begin
                tests_run++;
                if (obs !== {32'h00010203, 4'b0111, 3'd3, 1'b0, 1'b0}) begin
                    tests_failed++;
                    $display("FAIL clamp0_three: got %h required %h", obs, {32'h00010203, 4'b0111, 3'd3, 1'b0, 1'b0});
                end
            end
        end
        tests_run++;
        if (obs !== {32'h01020304, 4'b1111, 3'd4, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL clamp0_four: got %h required %h", obs, {32'h01020304, 4'b1111, 3'd4, 1'b1, 1'b0});
        end
        in_we = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        tests_run++;
        if (obs !== {32'h02030400, 4'b1110, 3'd3, 1'b1, 1'b1}) begin
            tests_failed++;
            $display("FAIL clamp0_drain: got %h required %h", obs, {32'h02030400, 4'b1110, 3'd3, 1'b1, 1'b1});
        end
        enable = 1'b0; flush = 1'b1; in_we = 1'b1;
        step();
        tests_run++;
        if (obs !== {32'h0, 4'b0000, 3'd0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL abort_enable: got %h required %h", obs, {32'h0, 4'b0000, 3'd0, 1'b0, 1'b0});
        end
        flush = 1'b0; in_we = 1'b0;
    endtask

    task automatic test_abort_reset();
        enable = 1'b1; win_rows = 3'd5;
        step();
        in_we = 1'b1; in_data = 8'h5A;
        step();
        in_data = 8'h6B;
        step();
        in_we = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        tests_run++;
        if (obs !== {32'h005A6B00, 4'b0110, 3'd2, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL clamp5_drain: got %h required %h", obs, {32'h005A6B00, 4'b0110, 3'd2, 1'b0, 1'b1});
        end
        rst_n = 1'b0; in_we = 1'b1; in_data = 8'h77;
        step();
        tests_run++;
        if (obs !== {32'h0, 4'b0000, 3'd0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL abort_reset: got %h required %h", obs, {32'h0, 4'b0000, 3'd0, 1'b0, 1'b0});
        end
        rst_n = 1'b1; in_we = 1'b0;
        step();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n = 1'b0; enable = 1'b0; in_we = 1'b0; flush = 1'b0;
        in_data = '0; win_rows = 3'd3;
        test_reset();
        test_fill();
        test_hold();
        test_overflow();
        test_drain();
        test_eff_one_write_flush();
        test_abort_enable();
        test_abort_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
